// File: rtl/unidade_load_store.sv
// Memory-stage load/store unit: lh/sh over an 8-bit RAM, split into two
// little-endian byte transactions with a request/acknowledge handshake.
module unidade_load_store #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inicio,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           endereco,
  input  logic [31:0]           dado_escrita,
  output logic                  ocupado,
  output logic                  pronto,
  output logic                  desalinhado,
  output logic [31:0]           dado_lido,
  output logic [ADDR_WIDTH-1:0] mem_endereco,
  output logic [7:0]            mem_dado_saida,
  input  logic [7:0]            mem_dado_entrada,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic                  mem_ack
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    BYTE0  = 2'd1,
    BYTE1  = 2'd2,
    FIM    = 2'd3
  } estado_t;

  estado_t               estado_q, estado_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  load_q, load_d;
  logic [7:0]            lo_q, lo_d;
  logic [31:0]           dado_lido_q, dado_lido_d;
  logic                  desal_q, desal_d;
  logic                  op_valida;

  logic unused_bits;
  assign unused_bits = ^{endereco[31:ADDR_WIDTH], dado_escrita[31:16]};

  assign op_valida = MemRead ^ MemWrite;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= OCIOSO;
      addr_q      <= '0;
      wdata_q     <= '0;
      load_q      <= 1'b0;
      lo_q        <= '0;
      dado_lido_q <= '0;
      desal_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      load_q      <= load_d;
      lo_q        <= lo_d;
      dado_lido_q <= dado_lido_d;
      desal_q     <= desal_d;
    end
  end

  always_comb begin
    estado_d    = estado_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    load_d      = load_q;
    lo_d        = lo_q;
    dado_lido_d = dado_lido_q;
    desal_d     = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (inicio && op_valida) begin
          if (endereco[0]) begin
            desal_d = 1'b1;
          end else begin
            addr_d   = endereco[ADDR_WIDTH-1:0];
            wdata_d  = dado_escrita[15:0];
            load_d   = MemRead;
            estado_d = BYTE0;
          end
        end
      end
      BYTE0: begin
        if (mem_ack) begin
          if (load_q) lo_d = mem_dado_entrada;
          estado_d = BYTE1;
        end
      end
      BYTE1: begin
        // Result is assembled on the high-byte ack so it is valid alongside pronto.
        if (mem_ack) begin
          if (load_q) dado_lido_d = {{16{mem_dado_entrada[7]}}, mem_dado_entrada, lo_q};
          estado_d = FIM;
        end
      end
      FIM: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // Memory side is decoded purely from registered state and latched request.
  always_comb begin
    mem_endereco   = '0;
    mem_dado_saida = '0;
    mem_re         = 1'b0;
    mem_we         = 1'b0;
    case (estado_q)
      BYTE0: begin
        mem_endereco   = addr_q;
        mem_dado_saida = load_q ? 8'h00 : wdata_q[7:0];
        mem_re         = load_q;
        mem_we         = !load_q;
      end
      BYTE1: begin
        mem_endereco   = {addr_q[ADDR_WIDTH-1:1], 1'b1};
        mem_dado_saida = load_q ? 8'h00 : wdata_q[15:8];
        mem_re         = load_q;
        mem_we         = !load_q;
      end
      default: begin
        mem_endereco   = '0;
      end
    endcase
  end

  assign ocupado     = (estado_q != OCIOSO);
  assign pronto      = (estado_q == FIM);
  assign desalinhado = desal_q;
  assign dado_lido   = dado_lido_q;

endmodule

// File: tb/tb_unidade_load_store.sv
// Directed bench for unidade_load_store: byte-wide RAM responder with
// configurable ack delay, access and result scoreboards.
module tb_unidade_load_store;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inicio = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] endereco = '0;
  logic [31:0] dado_escrita = '0;
  logic        ocupado, pronto, desalinhado;
  logic [31:0] dado_lido;
  logic [11:0] mem_endereco;
  logic [7:0]  mem_dado_saida;
  logic [7:0]  mem_dado_entrada = '0;
  logic        mem_re, mem_we;
  logic        mem_ack = 1'b0;

  unidade_load_store #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .MemRead(MemRead), .MemWrite(MemWrite),
    .endereco(endereco), .dado_escrita(dado_escrita), .ocupado(ocupado), .pronto(pronto),
    .desalinhado(desalinhado), .dado_lido(dado_lido), .mem_endereco(mem_endereco),
    .mem_dado_saida(mem_dado_saida), .mem_dado_entrada(mem_dado_entrada),
    .mem_re(mem_re), .mem_we(mem_we), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [7:0]  data;
  } acc_t;

  acc_t        q_acc[$];
  logic [31:0] q_res[$];
  logic [7:0]  ram [0:4095];
  int          n_cmp = 0;
  int          n_err = 0;
  int          ack_delay = 0;
  logic [31:0] exp_lido = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push_lh(input logic [11:0] a);
    logic [11:0] a1;
    a1 = a | 12'h001;
    q_acc.push_back({1'b0, a, 8'h00});
    q_acc.push_back({1'b0, a1, 8'h00});
    exp_lido = {{16{ram[a1][7]}}, ram[a1], ram[a]};
    q_res.push_back(exp_lido);
  endtask

  task automatic push_sh(input logic [11:0] a, input logic [15:0] d);
    logic [11:0] a1;
    a1 = a | 12'h001;
    q_acc.push_back({1'b1, a, d[7:0]});
    q_acc.push_back({1'b1, a1, d[15:8]});
    q_res.push_back(exp_lido);
  endtask

  // Issue one request and follow it to pronto; poke keeps a valid inicio alive while busy.
  task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input int dly, input bit poke);
    int cyc;
    logic [31:0] exp_r;
    ack_delay = dly;
    @(negedge clk);
    inicio = 1'b1; MemRead = rd; MemWrite = wr; endereco = a; dado_escrita = wd;
    @(posedge clk); #1;
    if (poke) begin
      MemRead = 1'b0; MemWrite = 1'b1; endereco = 32'h0000_0100;
    end else begin
      inicio = 1'b0;
    end
    chk("busy_after_start", ocupado, 1);
    chk("desal_low", desalinhado, 0);
    cyc = 1;
    while (!pronto && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    inicio = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    chk("pronto", pronto, 1);
    chk("latency", cyc, 3 + 2 * dly);
    exp_r = (q_res.size() > 0) ? q_res.pop_front() : 32'hxxxx_xxxx;
    chk("dado_lido", dado_lido, exp_r);
    @(posedge clk); #1;
    chk("idle_after", ocupado, 0);
    chk("pronto_pulse", pronto, 0);
  endtask

  initial begin
    int wcnt;
    acc_t e;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h010] = 8'h34; ram[12'h011] = 8'h82;
    ram[12'h002] = 8'h7F; ram[12'h003] = 8'h00;
    ram[12'h040] = 8'h55; ram[12'h041] = 8'hA6;

    fork
      begin
        wcnt = 0;
        forever begin
          @(negedge clk);
          if (mem_re || mem_we) begin
            if (wcnt == ack_delay) begin
              mem_ack = 1'b1;
              if (q_acc.size() == 0) begin
                chk("unexpected_strobe", {30'd0, mem_re, mem_we}, 0);
              end else begin
                e = q_acc.pop_front();
                chk("acc_we", mem_we, e.we);
                chk("acc_re", mem_re, !e.we);
                chk("acc_addr", mem_endereco, e.addr);
                chk("acc_data", mem_dado_saida, e.data);
              end
              if (mem_we) ram[mem_endereco] = mem_dado_saida;
              else mem_dado_entrada = ram[mem_endereco];
              wcnt = 0;
            end else begin
              mem_ack = 1'b0;
              wcnt++;
            end
          end else begin
            mem_ack = 1'b0;
            wcnt = 0;
          end
        end
      end
    join_none

    #1;
    chk("rst_ocupado", ocupado, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_desal", desalinhado, 0);
    chk("rst_re", mem_re, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_lido", dado_lido, 0);
    chk("rst_addr", mem_endereco, 0);
    chk("rst_wdata", mem_dado_saida, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    repeat (10) begin
      @(posedge clk); #1;
      chk("idle_strobe", {30'd0, mem_re, mem_we}, 0);
    end

    push_lh(12'h010);
    req(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 1'b0);

    push_sh(12'h020, 16'h1234);
    req(1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_1234, 2, 1'b0);
    chk("ram_020", ram[12'h020], 32'h34);
    chk("ram_021", ram[12'h021], 32'h12);

    @(negedge clk);
    inicio = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; endereco = 32'h0000_0003;
    @(posedge clk); #1;
    inicio = 1'b0;
    chk("desal_pulse", desalinhado, 1);
    chk("desal_not_busy", ocupado, 0);
    push_lh(12'h002);
    req(1'b1, 1'b0, 32'h0000_0002, 32'h0, 0, 1'b0);

    @(negedge clk);
    inicio = 1'b1; MemRead = 1'b1; MemWrite = 1'b1; endereco = 32'h0000_0010;
    repeat (2) begin
      @(posedge clk); #1;
      chk("both_ignored_busy", ocupado, 0);
      chk("both_ignored_desal", desalinhado, 0);
    end
    inicio = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;

    push_lh(12'h040);
    req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 1'b1);

    push_lh(12'h040);
    ack_delay = 0;
    @(negedge clk);
    inicio = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; endereco = 32'h0000_0040;
    @(posedge clk); #1;
    inicio = 1'b0; MemRead = 1'b0;
    @(posedge clk); #1;
    chk("byte1_re", mem_re, 1);
    chk("byte1_addr", mem_endereco, 32'h041);
    rst_n = 1'b0;
    #1;
    chk("abort_re", mem_re, 0);
    chk("abort_busy", ocupado, 0);
    chk("abort_lido", dado_lido, 0);
    q_acc.delete();
    q_res.delete();
    exp_lido = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_pronto", pronto, 0);
    end

    push_lh(12'h010);
    req(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 1'b0);

    chk("acc_queue_drained", q_acc.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/unidade_load_store.md
# unidade_load_store

Load/store unit for the single-cycle datapath's memory stage: consumes the ALU result as a byte address and executes `lh`/`sh` against an 8-bit-wide data RAM. Each access is split into two byte transactions over a request/acknowledge handshake. Loads return a sign-extended 32-bit halfword to write-back. Misaligned halfword accesses are rejected without touching memory.

## Interface
- `ADDR_WIDTH`, default 12: RAM byte-address width; uses `endereco[ADDR_WIDTH-1:0]`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `inicio` in 1: start request, sampled only in OCIOSO.
- `MemRead` in 1: request is `lh`.
- `MemWrite` in 1: request is `sh`.
- `endereco` in 32: ALU result, byte address.
- `dado_escrita` in 32: store data; bits [15:0] are written.
- `ocupado` out 1: unit busy.
- `pronto` out 1: one-cycle completion pulse.
- `desalinhado` out 1: one-cycle pulse; request rejected because `endereco[0]`=1.
- `dado_lido` out 32: last loaded halfword, sign-extended.
- `mem_endereco` out ADDR_WIDTH: RAM byte address.
- `mem_dado_saida` out 8: RAM write byte.
- `mem_dado_entrada` in 8: RAM read byte, valid with `mem_ack`.
- `mem_re` out 1: RAM read strobe.
- `mem_we` out 1: RAM write strobe.
- `mem_ack` in 1: RAM transaction complete.

## Operation
- States: OCIOSO, BYTE0, BYTE1, FIM. Little-endian: low byte at `addr`, high byte at `addr+1`.
- OCIOSO, `inicio`=1, exactly one of `MemRead`/`MemWrite` set, `endereco[0]`=0:
  - latch address [ADDR_WIDTH-1:0], `dado_escrita[15:0]`, and op;
  - next state BYTE0.
- OCIOSO, `inicio`=1, valid op, `endereco[0]`=1: `desalinhado`=1 next cycle; stay OCIOSO; no memory strobe.
- OCIOSO, `inicio`=1, `MemRead`=`MemWrite` (both 0 or both 1): ignored; no pulse; stay OCIOSO.
- BYTE0:
  - `mem_endereco`=addr; `mem_re` (load) or `mem_we` (store) =1; `mem_dado_saida`=data[7:0] for stores, 0 for loads.
  - Strobe held until `mem_ack`=1 is sampled.
  - On ack: loads capture `mem_dado_entrada` as low byte; go BYTE1.
- BYTE1: same as BYTE0 with `mem_endereco`=addr|1 and data[15:8]. On ack: loads capture high byte; go FIM. Aligned address, so no carry/wrap.
- FIM:
  - `pronto`=1;
  - loads: `dado_lido`={{16{hi[7]}},hi,lo}; stores leave `dado_lido` unchanged;
  - next state OCIOSO.
- `ocupado`=1 in BYTE0, BYTE1, FIM. `inicio` is ignored whenever `ocupado`=1.
- `mem_ack` is ignored outside BYTE0/BYTE1. `mem_dado_entrada` is sampled only when `mem_ack`=1.
- Memory outputs are decoded from registered state and latched data only. There is no combinational path from any input to `mem_*`.

## Timing
- Reset (async assert, sync release): state OCIOSO. `ocupado`, `pronto`, `desalinhado`, `mem_re`, `mem_we`=0. `dado_lido`, `mem_endereco`, `mem_dado_saida`=0.
- Reset mid-access aborts immediately: strobes drop without waiting for a clock. The partial load is discarded and `dado_lido` is cleared.
- Minimum latency (ack in the same cycle as strobe): `inicio` sampled at edge N; BYTE0 in cycle N+1; BYTE1 in N+2; FIM (`pronto`=1) in N+3; OCIOSO in N+4. The next `inicio` is accepted at edge N+4.
- Each ack wait cycle adds exactly one cycle to total latency.
- `desalinhado` is high in cycle N+1 only. A new request is accepted at edge N+1.
- A store's second byte is never issued before the first byte's ack.

## Test plan
- Reset then idle: all outputs 0; `inicio`=0 for 10 cycles -> no strobes.
- `lh` at 0x010, RAM[0x010]=0x34, RAM[0x011]=0x82, ack immediate -> `mem_re` at addr 0x010 then 0x011; `pronto` at N+3; `dado_lido`=0xFFFF8234.
- `sh` at 0x020, `dado_escrita`=0xDEAD1234, ack delayed 2 cycles per byte -> RAM[0x020]=0x34, RAM[0x021]=0x12; `pronto` at N+7; `dado_lido` unchanged.
- `lh` at 0x003 -> `desalinhado` pulse at N+1, no strobe; then `lh` at 0x002 with RAM 0x7F,0x00 -> `dado_lido`=0x0000007F.
- `inicio` with `MemRead`=`MemWrite`=1, and `inicio` asserted while busy -> both ignored; no strobe beyond the active access.
- `rst_n` low during BYTE1 -> `mem_re`=0 immediately, no `pronto`, `dado_lido`=0; next `lh` completes normally.
